// File: rtl/wb_regfile_if.sv
// ============================================================================
// Module  : wb_regfile_if
// Brief   : Bus bundle for the write-back register file (write port, two reads).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] bus_D;
    logic [ADDR_W-1:0] DA;
    logic              RW;
    logic [ADDR_W-1:0] AA;
    logic [ADDR_W-1:0] BA;
    logic [DATA_W-1:0] A_data;
    logic [DATA_W-1:0] B_data;
    logic              wb_pending;
    logic [7:0]        wr_count;

    modport master (
        output bus_D, DA, RW, AA, BA,
        input  A_data, B_data, wb_pending, wr_count
    );

    modport slave (
        input  bus_D, DA, RW, AA, BA,
        output A_data, B_data, wb_pending, wr_count
    );
endinterface

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// Module  : wb_regfile
// Brief   : 2**ADDR_W x DATA_W register file with a one-deep write-back stage
//           and read bypass from that stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  wire logic     clk,
    input  wire logic     rst,
    wb_regfile_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [7:0]        wr_count;

    // Capture into the write-back stage and retire the previous capture on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wr_count <= 8'd0;
        end else begin
            wb_valid <= bus.RW;
            if (bus.RW) begin
                wb_addr <= bus.DA;
                wb_data <= bus.bus_D;
            end
            if (wb_valid) begin
                regs[wb_addr] <= wb_data;
                wr_count      <= wr_count + 8'd1;
            end
        end
    end

    // Reads see only registered state, never the live bus_D.
    always_comb begin
        bus.A_data = (wb_valid && (bus.AA == wb_addr)) ? wb_data : regs[bus.AA];
        bus.B_data = (wb_valid && (bus.BA == wb_addr)) ? wb_data : regs[bus.BA];
    end

    assign bus.wb_pending = wb_valid;
    assign bus.wr_count   = wr_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module  : tb_wb_regfile
// Brief   : Self-checking bench for wb_regfile: vector table plus hand sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;
    logic clk;
    logic rst;

    wb_regfile_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    wb_regfile #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [2:0] da;
        logic [7:0] d;
        logic [2:0] aa;
        logic [2:0] ba;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ep;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs [16];
    vec_t sb [$];
    vec_t cur;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tmp;

        // rw, da, d, aa, ba, expA, expB, pending, count (observed after the edge)
        vecs[0]  = '{1'b1, 3'd2, 8'hC3, 3'd2, 3'd2, 8'hC3, 8'hC3, 1'b1, 8'd0};
        vecs[1]  = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 8'hC3, 8'hC3, 1'b0, 8'd1};
        vecs[2]  = '{1'b1, 3'd5, 8'h11, 3'd5, 3'd5, 8'h11, 8'h11, 1'b1, 8'd1};
        vecs[3]  = '{1'b1, 3'd5, 8'h22, 3'd5, 3'd5, 8'h22, 8'h22, 1'b1, 8'd2};
        vecs[4]  = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 8'h22, 8'h22, 1'b0, 8'd3};
        vecs[5]  = '{1'b1, 3'd1, 8'hAA, 3'd1, 3'd6, 8'hAA, 8'h00, 1'b1, 8'd3};
        vecs[6]  = '{1'b1, 3'd6, 8'h55, 3'd1, 3'd6, 8'hAA, 8'h55, 1'b1, 8'd4};
        vecs[7]  = '{1'b0, 3'd0, 8'h00, 3'd1, 3'd6, 8'hAA, 8'h55, 1'b0, 8'd5};
        vecs[8]  = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd5, 8'hC3, 8'h22, 1'b0, 8'd5};
        vecs[9]  = '{1'b1, 3'd2, 8'h0F, 3'd2, 3'd1, 8'h0F, 8'hAA, 1'b1, 8'd5};
        vecs[10] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 8'h0F, 8'h0F, 1'b0, 8'd6};
        vecs[11] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 8'h00, 8'h00, 1'b0, 8'd6};
        vecs[12] = '{1'b1, 3'd7, 8'h99, 3'd7, 3'd7, 8'h99, 8'h99, 1'b1, 8'd6};
        vecs[13] = '{1'b1, 3'd7, 8'h99, 3'd7, 3'd7, 8'h99, 8'h99, 1'b1, 8'd7};
        vecs[14] = '{1'b1, 3'd7, 8'h99, 3'd7, 3'd7, 8'h99, 8'h99, 1'b1, 8'd8};
        vecs[15] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd7, 8'h99, 8'h99, 1'b0, 8'd9};

        rst = 1'b1;
        bus.RW = 1'b0; bus.DA = '0; bus.bus_D = '0; bus.AA = 3'd3; bus.BA = 3'd3;
        #1;
        check("reset_A", bus.A_data, 8'h00);
        check("reset_B", bus.B_data, 8'h00);
        check("reset_pending", {7'd0, bus.wb_pending}, 8'd0);
        check("reset_count", bus.wr_count, 8'd0);

        // RW must be ignored while reset is held
        bus.RW = 1'b1; bus.DA = 3'd3; bus.bus_D = 8'hFF;
        tick();
        check("rw_in_reset_pending", {7'd0, bus.wb_pending}, 8'd0);
        check("rw_in_reset_A", bus.A_data, 8'h00);
        bus.RW = 1'b0;
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            bus.RW = vecs[k].rw; bus.DA = vecs[k].da; bus.bus_D = vecs[k].d;
            bus.AA = vecs[k].aa; bus.BA = vecs[k].ba;
            sb.push_back(vecs[k]);
            tick();
            cur = sb.pop_front();
            check($sformatf("vec%0d_A", k), bus.A_data, cur.ea);
            check($sformatf("vec%0d_B", k), bus.B_data, cur.eb);
            check($sformatf("vec%0d_pending", k), {7'd0, bus.wb_pending}, {7'd0, cur.ep});
            check($sformatf("vec%0d_count", k), bus.wr_count, cur.ec);
        end

        // Live bus_D must not reach the read ports before the edge
        bus.RW = 1'b1; bus.DA = 3'd4; bus.bus_D = 8'h77; bus.AA = 3'd4;
        #1;
        check("nofwd_before_edge", bus.A_data, 8'h00);
        tick();
        check("nofwd_after_edge", bus.A_data, 8'h77);
        check("nofwd_pending", {7'd0, bus.wb_pending}, 8'd1);
        bus.RW = 1'b0;

        // Asynchronous reset clears a retired register before any edge
        bus.RW = 1'b1; bus.DA = 3'd3; bus.bus_D = 8'h5A; bus.AA = 3'd3;
        tick();
        bus.RW = 1'b0;
        tick();
        check("r3_written", bus.A_data, 8'h5A);
        check("r3_retired", {7'd0, bus.wb_pending}, 8'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_A", bus.A_data, 8'h00);
        check("async_rst_pending", {7'd0, bus.wb_pending}, 8'd0);
        check("async_rst_count", bus.wr_count, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while a write is pending discards it
        bus.RW = 1'b1; bus.DA = 3'd6; bus.bus_D = 8'hEE; bus.AA = 3'd6;
        @(posedge clk);
        #1;
        bus.RW = 1'b0;
        check("discard_pending_before", {7'd0, bus.wb_pending}, 8'd1);
        rst = 1'b1;
        #1;
        check("discard_pending_after", {7'd0, bus.wb_pending}, 8'd0);
        check("discard_A_in_reset", bus.A_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("discard_A_after", bus.A_data, 8'h00);
        check("discard_count", bus.wr_count, 8'd0);

        // 256 consecutive writes: counter wraps back to zero once the last retires
        bus.RW = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tmp = i[7:0];
            bus.DA = tmp[2:0];
            bus.bus_D = tmp;
            tick();
        end
        check("wrap_count_255", bus.wr_count, 8'd255);
        check("wrap_pending", {7'd0, bus.wb_pending}, 8'd1);
        bus.RW = 1'b0;
        tick();
        check("wrap_count_0", bus.wr_count, 8'd0);
        bus.AA = 3'd0; bus.BA = 3'd7;
        #1;
        check("wrap_r0", bus.A_data, 8'hF8);
        check("wrap_r7", bus.B_data, 8'hFF);
        bus.BA = 3'd0;
        #1;
        check("same_reg_both_ports", bus.B_data, 8'hF8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
